// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code evaluation slice:
// flag bit positions, x86 tttn encodings and a flag packing helper.
package cc_pkg;

    localparam int unsigned FLAGS_W = 5;

    // Bit positions inside the architectural flags vector {OF,SF,ZF,PF,CF}
    localparam int unsigned FLAG_CF = 0;
    localparam int unsigned FLAG_PF = 1;
    localparam int unsigned FLAG_ZF = 2;
    localparam int unsigned FLAG_SF = 3;
    localparam int unsigned FLAG_OF = 4;

    // x86 tttn condition codes; odd codes invert the preceding even code
    localparam logic [3:0] CC_O   = 4'h0;
    localparam logic [3:0] CC_NO  = 4'h1;
    localparam logic [3:0] CC_B   = 4'h2;
    localparam logic [3:0] CC_NB  = 4'h3;
    localparam logic [3:0] CC_E   = 4'h4;
    localparam logic [3:0] CC_NE  = 4'h5;
    localparam logic [3:0] CC_BE  = 4'h6;
    localparam logic [3:0] CC_NBE = 4'h7;
    localparam logic [3:0] CC_S   = 4'h8;
    localparam logic [3:0] CC_NS  = 4'h9;
    localparam logic [3:0] CC_P   = 4'hA;
    localparam logic [3:0] CC_NP  = 4'hB;
    localparam logic [3:0] CC_L   = 4'hC;
    localparam logic [3:0] CC_NL  = 4'hD;
    localparam logic [3:0] CC_LE  = 4'hE;
    localparam logic [3:0] CC_NLE = 4'hF;

    // Assemble a flags vector from individual flag bits
    function automatic logic [FLAGS_W-1:0] pack_flags(
        input logic cf,
        input logic pf,
        input logic zf,
        input logic sf,
        input logic of
    );
        logic [FLAGS_W-1:0] f;
        f          = '0;
        f[FLAG_CF] = cf;
        f[FLAG_PF] = pf;
        f[FLAG_ZF] = zf;
        f[FLAG_SF] = sf;
        f[FLAG_OF] = of;
        return f;
    endfunction

endpackage

// File: rtl/cc_decode.sv
// Combinational tttn evaluator: {flags, code} -> taken.
// Shared between the Jcc/SETcc path and the CMOV path.
module cc_decode
    import cc_pkg::*;
(
    input  logic [FLAGS_W-1:0] i_flags,
    input  logic [3:0]         i_code,
    output logic               o_taken
);

    logic w_base;

    // Evaluate the even (non-inverted) condition selected by code[3:1]
    always_comb begin
        w_base = 1'b0;
        case (i_code & 4'hE)
            CC_O:    w_base = i_flags[FLAG_OF];
            CC_B:    w_base = i_flags[FLAG_CF];
            CC_E:    w_base = i_flags[FLAG_ZF];
            CC_BE:   w_base = i_flags[FLAG_CF] | i_flags[FLAG_ZF];
            CC_S:    w_base = i_flags[FLAG_SF];
            CC_P:    w_base = i_flags[FLAG_PF];
            CC_L:    w_base = i_flags[FLAG_SF] ^ i_flags[FLAG_OF];
            CC_LE:   w_base = i_flags[FLAG_ZF] | (i_flags[FLAG_SF] ^ i_flags[FLAG_OF]);
            default: w_base = 1'b0;
        endcase
    end

    assign o_taken = w_base ^ i_code[0];

endmodule

// File: rtl/cc_eval_unit.sv
// Execute-stage condition-code consumer: latches comparator/ALU flags,
// counts in-flight flag writers, evaluates tttn requests in order and
// returns results through a 2-entry response FIFO.
module cc_eval_unit
    import cc_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned PEND_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               alloc_valid,
    output logic               alloc_ready,
    input  logic               flg_valid,
    input  logic               flg_sub,
    input  logic               flg_carry,
    input  logic               flg_pf,
    input  logic               flg_zf,
    input  logic               flg_sf,
    input  logic               flg_of,
    input  logic               cc_valid,
    output logic               cc_ready,
    input  logic [3:0]         cc_code,
    input  logic [ID_W-1:0]    cc_id,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_taken,
    output logic [ID_W-1:0]    res_id,
    output logic [FLAGS_W-1:0] flags,
    output logic               err_unalloc
);

    logic [PEND_W-1:0]  r_pending;
    logic [FLAGS_W-1:0] r_flags;
    logic               r_err;

    // FIFO held as head/tail registers so the response outputs come straight from flops
    logic               r_head_valid;
    logic               r_head_taken;
    logic [ID_W-1:0]    r_head_id;
    logic               r_tail_valid;
    logic               r_tail_taken;
    logic [ID_W-1:0]    r_tail_id;

    logic [PEND_W-1:0]  w_pend_next;
    logic [FLAGS_W-1:0] w_in_flags;
    logic [FLAGS_W-1:0] w_eval_flags;
    logic               w_alloc_ready;
    logic               w_alloc_fire;
    logic               w_bypass;
    logic               w_resolvable;
    logic               w_cc_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_taken;

    // Comparator carry becomes a borrow for subtract/compare writebacks
    assign w_in_flags = pack_flags(flg_sub ? ~flg_carry : flg_carry,
                                   flg_pf, flg_zf, flg_sf, flg_of);

    assign w_alloc_ready = (r_pending != '1);
    assign w_alloc_fire  = alloc_valid & w_alloc_ready & ~flush;

    // The only outstanding writer retires this cycle and no new one arrives
    assign w_bypass     = (r_pending == PEND_W'(1)) & flg_valid & ~alloc_valid;
    assign w_resolvable = (r_pending == '0) | w_bypass;
    // A full FIFO blocks even if a pop happens this cycle: no res_ready -> cc_ready path
    assign w_cc_ready   = w_resolvable & ~r_tail_valid;
    assign w_eval_flags = w_bypass ? w_in_flags : r_flags;

    assign w_push = cc_valid & w_cc_ready & ~flush;
    assign w_pop  = r_head_valid & res_ready;

    cc_decode u_decode (
        .i_flags (w_eval_flags),
        .i_code  (cc_code),
        .o_taken (w_taken)
    );

    // Pending-writer count; an unallocated writeback at zero must not underflow
    always_comb begin
        w_pend_next = r_pending;
        if (flush) begin
            w_pend_next = '0;
        end else if (flg_valid && (r_pending == '0)) begin
            w_pend_next = '0;
        end else begin
            w_pend_next = r_pending + PEND_W'(w_alloc_fire) - PEND_W'(flg_valid);
        end
    end

    // Counter, flags and sticky error state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_flags   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pending <= w_pend_next;
            if (flg_valid) begin
                r_flags <= w_in_flags;
            end
            if (flg_valid && (r_pending == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // In-order 2-entry response FIFO with simultaneous push/pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_valid <= 1'b0;
            r_head_taken <= 1'b0;
            r_head_id    <= '0;
            r_tail_valid <= 1'b0;
            r_tail_taken <= 1'b0;
            r_tail_id    <= '0;
        end else if (flush) begin
            r_head_valid <= 1'b0;
            r_tail_valid <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_valid) begin
                r_head_valid <= 1'b1;
                r_head_taken <= r_tail_taken;
                r_head_id    <= r_tail_id;
                r_tail_valid <= w_push;
                if (w_push) begin
                    r_tail_taken <= w_taken;
                    r_tail_id    <= cc_id;
                end
            end else begin
                r_head_valid <= w_push;
                if (w_push) begin
                    r_head_taken <= w_taken;
                    r_head_id    <= cc_id;
                end
            end
        end else if (w_push) begin
            if (r_head_valid) begin
                r_tail_valid <= 1'b1;
                r_tail_taken <= w_taken;
                r_tail_id    <= cc_id;
            end else begin
                r_head_valid <= 1'b1;
                r_head_taken <= w_taken;
                r_head_id    <= cc_id;
            end
        end
    end

    assign alloc_ready = w_alloc_ready;
    assign cc_ready    = w_cc_ready;
    assign res_valid   = r_head_valid;
    assign res_taken   = r_head_taken;
    assign res_id      = r_head_id;
    assign flags       = r_flags;
    assign err_unalloc = r_err;

endmodule

// File: tb/tb_cc_eval_unit.sv
// Directed testbench for cc_eval_unit with hand-computed expectations.
module tb_cc_eval_unit;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       alloc_valid;
    logic       alloc_ready;
    logic       flg_valid;
    logic       flg_sub;
    logic       flg_carry;
    logic       flg_pf;
    logic       flg_zf;
    logic       flg_sf;
    logic       flg_of;
    logic       cc_valid;
    logic       cc_ready;
    logic [3:0] cc_code;
    logic [3:0] cc_id;
    logic       res_valid;
    logic       res_ready;
    logic       res_taken;
    logic [3:0] res_id;
    logic [4:0] flags;
    logic       err_unalloc;

    int errors = 0;
    int checks = 0;

    cc_eval_unit #(
        .ID_W   (4),
        .PEND_W (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .flg_valid   (flg_valid),
        .flg_sub     (flg_sub),
        .flg_carry   (flg_carry),
        .flg_pf      (flg_pf),
        .flg_zf      (flg_zf),
        .flg_sf      (flg_sf),
        .flg_of      (flg_of),
        .cc_valid    (cc_valid),
        .cc_ready    (cc_ready),
        .cc_code     (cc_code),
        .cc_id       (cc_id),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_taken   (res_taken),
        .res_id      (res_id),
        .flags       (flags),
        .err_unalloc (err_unalloc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flg(input logic v, input logic sub, input logic carry,
                           input logic pf, input logic zf, input logic sf, input logic of);
        flg_valid = v;
        flg_sub   = sub;
        flg_carry = carry;
        flg_pf    = pf;
        flg_zf    = zf;
        flg_sf    = sf;
        flg_of    = of;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; cc_valid = 1'b0;
        cc_code = 4'h0; cc_id = 4'h0; res_ready = 1'b1;
        set_flg(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL reset_res_taken: got %b want 0", res_taken); end
        checks++; if (res_id !== 4'h0) begin errors++; $display("FAIL reset_res_id: got %h want 0", res_id); end
        checks++; if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b want 00000", flags); end
        checks++; if (err_unalloc !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_unalloc); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
        checks++; if (cc_ready !== 1'b1) begin errors++; $display("FAIL reset_cc_ready: got %b want 1", cc_ready); end
        reset = 1'b0;
        tick();
    endtask

    // Flags are all zero: E not taken, NE taken, one-cycle latency
    task automatic test_basic();
        cc_valid = 1'b1; cc_code = 4'h4; cc_id = 4'h5;
        #1;
        checks++; if (cc_ready !== 1'b1) begin errors++; $display("FAIL basic_cc_ready: got %b want 1", cc_ready); end
        tick();
        cc_valid = 1'b0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_res_valid: got %b want 1", res_valid); end
        checks++; if (res_taken !== 1'b0) begin errors++; $display("FAIL basic_taken_E: got %b want 0", res_taken); end
        checks++; if (res_id !== 4'h5) begin errors++; $display("FAIL basic_id: got %h want 5", res_id); end
        cc_valid = 1'b1; cc_code = 4'h5; cc_id = 4'h6;
        tick();
        cc_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_id !== 4'h6) begin
            errors++; $display("FAIL basic_NE: got v=%b t=%b id=%h want v=1 t=1 id=6", res_valid, res_taken, res_id); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", res_valid); end
    endtask

    // Stall behind one pending writer, then resolve via same-cycle bypass
    task automatic test_bypass();
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        cc_valid = 1'b1; cc_code = 4'h4; cc_id = 4'h3;
        #1;
        checks++; if (cc_ready !== 1'b0) begin errors++; $display("FAIL bypass_stall: got %b want 0", cc_ready); end
        tick();
        checks++; if (cc_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++; $display("FAIL bypass_hold: got rdy=%b v=%b want rdy=0 v=0", cc_ready, res_valid); end
        // a=b=0x05: sub, carry=1 -> CF=0, ZF=1, PF(0x00)=1
        set_flg(1, 1, 1, 1, 1, 0, 0);
        #1;
        checks++; if (cc_ready !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b want 1", cc_ready); end
        tick();
        set_flg(0, 0, 0, 0, 0, 0, 0);
        cc_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_id !== 4'h3) begin
            errors++; $display("FAIL bypass_result: got v=%b t=%b id=%h want v=1 t=1 id=3", res_valid, res_taken, res_id); end
        checks++; if (flags !== 5'b00110) begin errors++; $display("FAIL bypass_flags: got %b want 00110", flags); end
        checks++; if (err_unalloc !== 1'b0) begin errors++; $display("FAIL bypass_err: got %b want 0", err_unalloc); end
        tick();
    endtask

    // 0xFF - 0x01: CF=0, PF(0xFE)=0, ZF=0, SF=1, OF=0
    task automatic test_conditions();
        logic [3:0] codes [3];
        logic       exp   [3];
        codes[0] = 4'hC; exp[0] = 1'b1;
        codes[1] = 4'h2; exp[1] = 1'b0;
        codes[2] = 4'h7; exp[2] = 1'b1;
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        set_flg(1, 1, 1, 0, 0, 1, 0);
        tick();
        set_flg(0, 0, 0, 0, 0, 0, 0);
        checks++; if (flags !== 5'b01000) begin errors++; $display("FAIL cond_flags: got %b want 01000", flags); end
        for (int i = 0; i < 3; i++) begin
            cc_valid = 1'b1; cc_code = codes[i]; cc_id = 4'(i + 8);
            tick();
            cc_valid = 1'b0;
            checks++; if (res_valid !== 1'b1 || res_taken !== exp[i] || res_id !== 4'(i + 8)) begin
                errors++; $display("FAIL cond_code_%h: got v=%b t=%b id=%h want v=1 t=%b id=%h",
                                   codes[i], res_valid, res_taken, res_id, exp[i], 4'(i + 8)); end
            tick();
        end
    endtask

    // FIFO fills at two entries, no pop credit in the same cycle, in-order drain
    task automatic test_back_to_back();
        res_ready = 1'b0;
        cc_valid = 1'b1; cc_code = 4'h4; cc_id = 4'h0;
        tick();
        cc_code = 4'h5; cc_id = 4'h1;
        tick();
        cc_code = 4'h8; cc_id = 4'h2;
        #1;
        checks++; if (cc_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_stall: got %b want 0", cc_ready); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_id !== 4'h0 || res_taken !== 1'b0) begin
            errors++; $display("FAIL b2b_head0: got v=%b t=%b id=%h want v=1 t=0 id=0", res_valid, res_taken, res_id); end
        res_ready = 1'b1;
        #1;
        checks++; if (cc_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_pop_credit: got %b want 0", cc_ready); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_id !== 4'h1 || res_taken !== 1'b1) begin
            errors++; $display("FAIL b2b_head1: got v=%b t=%b id=%h want v=1 t=1 id=1", res_valid, res_taken, res_id); end
        tick();
        cc_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_id !== 4'h2 || res_taken !== 1'b1) begin
            errors++; $display("FAIL b2b_head2: got v=%b t=%b id=%h want v=1 t=1 id=2", res_valid, res_taken, res_id); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", res_valid); end
    endtask

    // Counter saturation, simultaneous alloc+write, then flush
    task automatic test_saturate_flush();
        res_ready = 1'b0;
        cc_valid = 1'b1; cc_code = 4'h0; cc_id = 4'h7;
        tick();
        cc_valid = 1'b0;
        alloc_valid = 1'b1;
        repeat (7) tick();
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL sat_alloc_ready: got %b want 0", alloc_ready); end
        checks++; if (cc_ready !== 1'b0) begin errors++; $display("FAIL sat_cc_ready: got %b want 0", cc_ready); end
        alloc_valid = 1'b0;
        set_flg(1, 0, 1, 1, 0, 0, 0);
        tick();
        checks++; if (alloc_ready !== 1'b1 || flags !== 5'b00011) begin
            errors++; $display("FAIL sat_write6: got rdy=%b f=%b want rdy=1 f=00011", alloc_ready, flags); end
        alloc_valid = 1'b1;
        set_flg(1, 1, 0, 0, 1, 0, 0);
        tick();
        set_flg(0, 0, 0, 0, 0, 0, 0);
        checks++; if (alloc_ready !== 1'b1 || flags !== 5'b00101) begin
            errors++; $display("FAIL sat_alloc_write: got rdy=%b f=%b want rdy=1 f=00101", alloc_ready, flags); end
        tick();
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL sat_back_to_7: got %b want 0", alloc_ready); end
        checks++; if (res_valid !== 1'b1 || res_id !== 4'h7) begin
            errors++; $display("FAIL sat_fifo_held: got v=%b id=%h want v=1 id=7", res_valid, res_id); end
        flush = 1'b1;
        cc_valid = 1'b1; cc_code = 4'h4; cc_id = 4'hA;
        tick();
        flush = 1'b0; alloc_valid = 1'b0; cc_valid = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_fifo: got %b want 0", res_valid); end
        checks++; if (alloc_ready !== 1'b1 || cc_ready !== 1'b1) begin
            errors++; $display("FAIL flush_pending: got ardy=%b crdy=%b want 1 1", alloc_ready, cc_ready); end
        checks++; if (flags !== 5'b00101 || err_unalloc !== 1'b0) begin
            errors++; $display("FAIL flush_flags: got f=%b err=%b want f=00101 err=0", flags, err_unalloc); end
        res_ready = 1'b1;
        tick();
    endtask

    // Writeback with nothing pending: flags load, sticky error, no underflow
    task automatic test_unalloc();
        set_flg(1, 0, 0, 0, 1, 0, 1);
        tick();
        set_flg(0, 0, 0, 0, 0, 0, 0);
        checks++; if (err_unalloc !== 1'b1) begin errors++; $display("FAIL unalloc_err: got %b want 1", err_unalloc); end
        checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL unalloc_flags: got %b want 10100", flags); end
        checks++; if (alloc_ready !== 1'b1 || cc_ready !== 1'b1) begin
            errors++; $display("FAIL unalloc_no_underflow: got ardy=%b crdy=%b want 1 1", alloc_ready, cc_ready); end
        tick();
        checks++; if (err_unalloc !== 1'b1) begin errors++; $display("FAIL unalloc_sticky: got %b want 1", err_unalloc); end
    endtask

    // Asynchronous reset while a request is stalled and the FIFO is occupied
    task automatic test_reset_mid();
        res_ready = 1'b0;
        cc_valid = 1'b1; cc_code = 4'h4; cc_id = 4'h9;
        tick();
        cc_valid = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_id !== 4'h9) begin
            errors++; $display("FAIL rmid_setup: got v=%b t=%b id=%h want v=1 t=1 id=9", res_valid, res_taken, res_id); end
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        cc_valid = 1'b1; cc_code = 4'h5; cc_id = 4'hB;
        tick();
        checks++; if (cc_ready !== 1'b0) begin errors++; $display("FAIL rmid_stalled: got %b want 0", cc_ready); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (res_valid !== 1'b0 || res_taken !== 1'b0 || res_id !== 4'h0) begin
            errors++; $display("FAIL rmid_res: got v=%b t=%b id=%h want 0 0 0", res_valid, res_taken, res_id); end
        checks++; if (flags !== 5'b00000 || err_unalloc !== 1'b0) begin
            errors++; $display("FAIL rmid_flags: got f=%b err=%b want 00000 0", flags, err_unalloc); end
        checks++; if (alloc_ready !== 1'b1 || cc_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_ready: got ardy=%b crdy=%b want 1 1", alloc_ready, cc_ready); end
        cc_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_conditions();
        test_back_to_back();
        test_saturate_flush();
        test_unalloc();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
